// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: fetches one word over a
// req/ready handshake, issues it to decode over valid/accept, picks next PC.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   stall, instr_accept      decode-side handshake (accept blocked by stall)
//   branch_taken, jump       redirect requests (jump has priority)
//   branch_offset_shifted    sign-extended immediate << 2
//   jump_index               J-type instr_index field
//   imem_ready, imem_rdata   instruction memory response
//   imem_req, imem_addr      instruction memory request
//   instr_out, instr_valid   held instruction for decode
//   pc, pc_plus4             current PC and PC+4
module pc_fetch_unit #(
    parameter int               Bits     = 32,
    parameter logic [Bits-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            instr_accept,
    input  logic            branch_taken,
    input  logic [Bits-1:0] branch_offset_shifted,
    input  logic            jump,
    input  logic [Bits-7:0] jump_index,
    input  logic            imem_ready,
    input  logic [Bits-1:0] imem_rdata,
    output logic            imem_req,
    output logic [Bits-1:0] imem_addr,
    output logic [Bits-1:0] instr_out,
    output logic            instr_valid,
    output logic [Bits-1:0] pc,
    output logic [Bits-1:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    localparam logic [Bits-1:0] RST_PC = {RESET_PC[Bits-1:2], 2'b00};

    state_e          state_q, state_d;
    logic [Bits-1:0] pc_q, pc_d;
    logic [Bits-1:0] instr_q, instr_d;
    logic [Bits-1:0] next_pc;
    logic [Bits-1:0] jump_tgt;
    logic [Bits-1:0] branch_tgt;
    logic            accept;

    assign pc_plus4   = pc_q + Bits'(4);
    assign jump_tgt   = {pc_plus4[Bits-1:Bits-4], jump_index, 2'b00};
    assign branch_tgt = pc_plus4 + branch_offset_shifted;
    assign accept     = instr_accept && !stall;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_tgt;
        end else if (branch_taken) begin
            next_pc = branch_tgt;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RST_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            // Low bits are cleared so pc stays word aligned whatever the offset.
            pc_q    <= {pc_d[Bits-1:2], 2'b00};
            instr_q <= instr_d;
        end
    end

    // Handshake outputs decode straight from state so reset drops them at once.
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_out   = instr_q;

endmodule
